uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//   8N1 UART transmitter with a small write FIFO; the transmit-side counterpart of the UART receiver.
//   Accepts bytes on a tx_wr strobe and serialises them LSB-first on uart_txd at a fixed baud rate.
//   Sits between the host/test logic (tx_data/tx_wr/tx_busy) and the board TXD pin.
//   Sends queued bytes back-to-back with no idle gap between frames.
// PARAMETERS
//   CLK_FREQ    50_000_000  input clock frequency in Hz
//   BAUD        115_200     line rate in bit/s; DIVISOR = CLK_FREQ/BAUD (truncated), must be >= 2
//   FIFO_DEPTH  4           write FIFO entries; power of two, >= 2
//   STOP_BITS   1           stop bits per frame; 1 or 2
// PORTS
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-low reset
//   tx_data   in   8  byte to send; sampled when tx_wr=1
//   tx_wr     in   1  write strobe, one byte per cycle high
//   tx_full   out  1  FIFO full; a write in this cycle is dropped
//   tx_busy   out  1  FIFO non-empty or a frame is in progress
//   uart_txd  out  1  serial output, idle high, registered
// BEHAVIOUR
//   Reset (async, reset=0): uart_txd=1, tx_busy=0, tx_full=0, FIFO empty, FSM=IDLE, counters=0.
//     Reset mid-frame abandons the frame. Line returns high at once. Queued bytes are flushed.
//   Write: at each rising edge with tx_wr=1 and tx_full=0 (pre-edge value), tx_data is pushed.
//     If tx_full=1, the write is dropped with no state change. There is no full-FIFO bypass, even
//     when a pop happens at the same edge. A push and a pop at the same edge on a non-full FIFO
//     both take effect; the count is unchanged.
//   FSM states: IDLE, START, DATA, STOP.
//     IDLE -> START: at the first edge where the FIFO is non-empty. The head is popped into the
//       shift register and uart_txd=0 from that edge.
//     START -> DATA after DIVISOR cycles. DATA sends bit0..bit7, DIVISOR cycles each, bit index 0..7.
//     DATA -> STOP after bit7. uart_txd=1 for STOP_BITS*DIVISOR cycles.
//     STOP -> START (pop at the same edge) if the FIFO is non-empty, else STOP -> IDLE.
//   Latency: write sampled at edge k into an empty FIFO while IDLE. Start bit begins at edge k+1.
//   Frame length: (9+STOP_BITS)*DIVISOR cycles, exact, with no jitter.
//   Baud counter: width $clog2(DIVISOR). Reloads to 0 at every bit boundary. Counts only in START/DATA/STOP.
//   tx_busy = (state!=IDLE) | fifo_not_empty.
//     Rises after the accepting edge. Falls at the edge that ends the last stop bit with the FIFO empty.
//   tx_full = (count==FIFO_DEPTH). Count width is $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
//   uart_txd is driven from a flop; no combinational path from inputs to the pin.
// STRUCTURE
//   uart_pkg: UART_DATA_BITS=8, tx FSM state encoding (IDLE/START/DATA/STOP), divisor function.
//   Sub-module uart_tx_fifo: synchronous FIFO (DEPTH, WIDTH=8) with push, pop, dout, empty, full.
//     Registered pointers and count. Same clk and reset.
//   The top level holds the FSM, baud counter, bit index and shift register.
// TESTING
//   1. Hold reset=0 for 10 cycles, toggle tx_wr -> uart_txd=1, tx_busy=0, tx_full=0 throughout.
//   2. CLK_FREQ=400, BAUD=100 (DIVISOR=4); write 0xA5
//      -> txd = 0,1,0,1,0,0,1,0,1,1, 4 cycles each (40 total); tx_busy falls at cycle 41.
//   3. Same clock; write 0x00, 0xFF, 0x55 on consecutive cycles
//      -> 3 contiguous frames (120 cycles), no high gap beyond the stop bits.
//   4. FIFO_DEPTH=4; write 0x01..0x06 on 6 consecutive edges k..k+5 -> 0x01..0x05 accepted.
//      tx_full=1 after edge k+4, 0x06 dropped, only 5 frames on the line.
//   5. Pull reset low during data bit 3 of 0xF0 -> uart_txd=1 and tx_busy=0 immediately.
//      After release, write 0x3C -> one clean 0x3C frame.
//   6. STOP_BITS=2, DIVISOR=4; write 0x81 -> stop high for 8 cycles, frame is 44 cycles,
//      next queued byte's start bit follows directly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg - shared UART constants, TX FSM encoding and divisor helper        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per bit; truncating division matches the line-rate tolerance we accept.
  function automatic int calc_divisor(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo - synchronous write FIFO feeding the UART transmitter          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  // A full FIFO rejects writes even if a pop frees a slot at the same edge.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == c_depth);

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_buffered - 8N1 UART transmitter with write FIFO, back-to-back TX    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       uart_txd
);

  localparam int c_divisor = calc_divisor(CLK_FREQ, BAUD);
  localparam int c_cnt_w   = (c_divisor > 2) ? $clog2(c_divisor) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(c_divisor - 1);
  localparam logic [2:0]         c_last_bit  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]         c_last_stop = 3'(STOP_BITS - 1);

  tx_state_t          r_state;
  logic [c_cnt_w-1:0] r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_txd;

  logic [7:0] w_fifo_dout;
  logic       w_fifo_empty;
  logic       w_bit_end;
  logic       w_frame_done;
  logic       w_pop;

  assign w_bit_end    = (r_baud_cnt == c_cnt_last);
  assign w_frame_done = (r_state == S_STOP) && w_bit_end && (r_bit_idx == c_last_stop);
  assign w_pop        = ~w_fifo_empty && ((r_state == S_IDLE) || w_frame_done);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .din   (tx_data),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (tx_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          if (w_pop) begin
            r_shift <= w_fifo_dout;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_txd      <= r_shift[0];
            r_shift    <= {1'b0, r_shift[7:1]};
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == c_last_bit) begin
              r_bit_idx <= '0;
              r_txd     <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (w_frame_done) begin
              r_bit_idx <= '0;
              // Chain straight into the next start bit so queued bytes leave no idle gap.
              if (w_pop) begin
                r_shift <= w_fifo_dout;
                r_txd   <= 1'b0;
                r_state <= S_START;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_txd = r_txd;
  assign tx_busy  = (r_state != S_IDLE) | ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_buffered - directed bench, 1- and 2-stop-bit instances, DIV=4     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_uart_tx_buffered;

  localparam int c_div = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d1, d2;
  logic       wr1, wr2;
  logic       full1, busy1, txd1;
  logic       full2, busy2, txd2;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLK_FREQ (400), .BAUD (100), .FIFO_DEPTH (4), .STOP_BITS (1)
  ) dut1 (
    .clk (clk), .reset (reset), .tx_data (d1), .tx_wr (wr1),
    .tx_full (full1), .tx_busy (busy1), .uart_txd (txd1)
  );

  uart_tx_buffered #(
    .CLK_FREQ (400), .BAUD (100), .FIFO_DEPTH (4), .STOP_BITS (2)
  ) dut2 (
    .clk (clk), .reset (reset), .tx_data (d2), .tx_wr (wr2),
    .tx_full (full2), .tx_busy (busy2), .uart_txd (txd2)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic txd;
    logic busy;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] pat;
  } vec_t;

  exp_t exp_q[$];
  logic rec_txd[$];
  logic rec_busy[$];
  logic rec_en = 1'b0;
  logic sel    = 1'b0;
  vec_t vecs[4];

  // Line recorder: one sample per clock, 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rec_en) begin
      rec_txd.push_back(sel ? txd2 : txd1);
      rec_busy.push_back(sel ? busy2 : busy1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_frame(input logic [10:0] pat, input int nb);
    for (int i = 0; i < nb; i++) exp_q.push_back('{txd: pat[i], busy: 1'b1});
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{txd: 1'b1, busy: 1'b0});
  endtask

  // Called at a negedge; the byte is sampled at the following rising edge.
  task automatic write_byte(input logic s, input logic [7:0] b);
    if (s) begin d2 = b; wr2 = 1'b1; end
    else   begin d1 = b; wr1 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    wr1 = 1'b0;
    wr2 = 1'b0;
  endtask

  task automatic start_capture(input logic s);
    sel = s;
    rec_txd.delete();
    rec_busy.delete();
    rec_en = 1'b1;
  endtask

  task automatic finish_capture(input string name);
    int   need;
    int   guard;
    int   idx;
    logic t_seen;
    logic b_seen;
    need  = exp_q.size() * c_div;
    guard = 0;
    while (rec_txd.size() < need && guard < need + 100) begin
      @(negedge clk);
      guard++;
    end
    rec_en = 1'b0;
    check({name, " samples"}, 32'(rec_txd.size()), 32'(need));
    for (int b = 0; b < exp_q.size(); b++) begin
      t_seen = exp_q[b].txd;
      b_seen = exp_q[b].busy;
      for (int c = 0; c < c_div; c++) begin
        idx = b * c_div + c;
        if (idx >= rec_txd.size()) begin
          t_seen = 1'bx;
          b_seen = 1'bx;
        end else begin
          if (rec_txd[idx] !== exp_q[b].txd)   t_seen = rec_txd[idx];
          if (rec_busy[idx] !== exp_q[b].busy) b_seen = rec_busy[idx];
        end
      end
      check($sformatf("%s bit%0d txd", name, b), 32'(t_seen), 32'(exp_q[b].txd));
      check($sformatf("%s bit%0d busy", name, b), 32'(b_seen), 32'(exp_q[b].busy));
    end
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic exp_full [5];
    exp_full = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Line patterns, bit i is the i-th bit on the wire (start, d0..d7, stop[s]).
    vecs[0] = '{8'hA5, 11'h34A};
    vecs[1] = '{8'h00, 11'h200};
    vecs[2] = '{8'hFF, 11'h3FE};
    vecs[3] = '{8'h55, 11'h2AA};

    reset = 1'b1;
    wr1 = 1'b0; wr2 = 1'b0; d1 = 8'h00; d2 = 8'h00;
    #1 reset = 1'b0;

    // Held in reset with write strobes toggling: everything stays idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("reset_idle cyc%0d", i),
            32'({txd1, busy1, full1, txd2, busy2, full2}), 32'(6'b100100));
      wr1 = ~wr1; wr2 = ~wr2; d1 = 8'hC3; d2 = 8'h3C;
    end
    wr1 = 1'b0; wr2 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'({txd1, busy1, full1, txd2, busy2, full2}), 32'(6'b100100));

    // Single frames from the table.
    foreach (vecs[v]) begin
      write_byte(1'b0, vecs[v].data);
      check($sformatf("accept_%02h busy/txd", vecs[v].data), 32'({busy1, txd1}), 32'(2'b11));
      start_capture(1'b0);
      add_frame(vecs[v].pat, 10);
      add_idle(2);
      finish_capture($sformatf("frame_%02h", vecs[v].data));
    end

    // Three bytes on consecutive cycles -> contiguous frames.
    write_byte(1'b0, 8'h00);
    start_capture(1'b0);
    write_byte(1'b0, 8'hFF);
    write_byte(1'b0, 8'h55);
    add_frame(11'h200, 10);
    add_frame(11'h3FE, 10);
    add_frame(11'h2AA, 10);
    add_idle(2);
    finish_capture("b2b3");

    // Overflow: 6 writes on consecutive edges, the sixth is dropped.
    write_byte(1'b0, 8'h01);
    start_capture(1'b0);
    for (int i = 0; i < 5; i++) begin
      write_byte(1'b0, 8'(i + 2));
      check($sformatf("full after edge k+%0d", i + 1), 32'(full1), 32'(exp_full[i]));
    end
    add_frame(11'h202, 10);
    add_frame(11'h204, 10);
    add_frame(11'h206, 10);
    add_frame(11'h208, 10);
    add_frame(11'h20A, 10);
    add_idle(2);
    finish_capture("overflow");
    check("full cleared", 32'(full1), 32'(0));

    // Reset during data bit 3 of 0xF0 with 0x11 queued behind it.
    write_byte(1'b0, 8'hF0);
    write_byte(1'b0, 8'h11);
    repeat (17) @(negedge clk);
    check("f0 in bit3", 32'({txd1, busy1}), 32'(2'b01));
    reset = 1'b0;
    #1;
    check("midframe reset", 32'({txd1, busy1, full1}), 32'(3'b100));
    @(negedge clk);
    @(negedge clk);
    check("reset held", 32'({txd1, busy1, full1}), 32'(3'b100));
    reset = 1'b1;
    @(negedge clk);
    write_byte(1'b0, 8'h3C);
    start_capture(1'b0);
    add_frame(11'h278, 10);
    add_idle(3);
    finish_capture("after_reset_3c");

    // Two stop bits, back-to-back.
    write_byte(1'b1, 8'h81);
    start_capture(1'b1);
    write_byte(1'b1, 8'h3C);
    add_frame(11'h702, 11);
    add_frame(11'h678, 11);
    add_idle(2);
    finish_capture("stop2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
